req_ack_stream_source: RTL

- Producer stage feeding a downstream req/ack data consumer.
- Buffers incoming bytes in a small FIFO and presents each byte with a four-phase req/ack handshake.
- Drives the consumer's `data_valid`, `data` and `req` inputs, and monitors `ack`.
- Reports protocol health on `no_error`, which is the signal the downstream deferred assertions check.

---
 rtl/req_ack_pkg.sv | 14 +
 rtl/req_ack_fifo.sv | 63 ++++++
 rtl/req_ack_stream_source.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/req_ack_pkg.sv
// Shared types and defaults for the req/ack stream source and its FIFO.
package req_ack_pkg;

   // Handshake FSM states
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      WAIT_LOW = 2'd2,
      ERR      = 2'd3
   } src_state_e;

   localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/req_ack_fifo.sv
// Small synchronous FIFO with a combinational head read (dout = oldest entry).
// Storage is not reset; pointers and occupancy are.
module req_ack_fifo
   import req_ack_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [DATA_W-1:0]          din,
   output logic [DATA_W-1:0]          dout,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Entry storage: written on accepted push only
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally (DEPTH is a power of two); occupancy tracks push/pop
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/req_ack_stream_source.sv
// Producer that buffers upstream bytes and presents each one to a consumer
// with a four-phase req/ack handshake, flagging protocol faults on no_error.
// Optional deferred protocol checks: define REQ_ACK_SRC_DEFERRED_ASSERT_EN.
module req_ack_stream_source
   import req_ack_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_W-1:0]          in_data,
   input  logic                       err_clr,
   output logic                       req,
   input  logic                       ack,
   output logic [DATA_W-1:0]          data,
   output logic                       data_valid,
   output logic                       no_error,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int TMR_W = $clog2(TIMEOUT+1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT-1);

   src_state_e        state;
   logic [TMR_W-1:0]  timer;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic              avail;
   logic [DATA_W-1:0] fifo_dout;

   assign in_ready = !full && !rst;
   assign push     = in_valid && in_ready;
   // avail is occupancy seen one cycle late, which sets the two-edge
   // push-to-req latency. It can never overstate occupancy in IDLE because
   // the edge that entered IDLE was never a pop.
   assign pop      = (state == IDLE) && !ack && avail && !empty && !rst;

   req_ack_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (in_data),
      .dout  (fifo_dout),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   // Handshake FSM with registered req/data/no_error and per-state timeout timer
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         timer      <= '0;
         req        <= 1'b0;
         data_valid <= 1'b0;
         data       <= '0;
         no_error   <= 1'b1;
         avail      <= 1'b0;
      end else begin
         avail <= (count != '0);
         case (state)
            IDLE: begin
               if (ack) begin
                  state    <= ERR;
                  no_error <= 1'b0;
                  timer    <= '0;
               end else if (pop) begin
                  state      <= REQ;
                  req        <= 1'b1;
                  data_valid <= 1'b1;
                  data       <= fifo_dout;
                  timer      <= '0;
               end
            end
            REQ: begin
               if (ack) begin
                  state      <= WAIT_LOW;
                  req        <= 1'b0;
                  data_valid <= 1'b0;
                  timer      <= '0;
               end else if (timer == TMR_LAST) begin
                  // Consumer never answered: the presented byte is abandoned
                  state      <= ERR;
                  req        <= 1'b0;
                  data_valid <= 1'b0;
                  no_error   <= 1'b0;
                  timer      <= '0;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            WAIT_LOW: begin
               if (!ack) begin
                  state <= IDLE;
                  timer <= '0;
               end else if (timer == TMR_LAST) begin
                  state    <= ERR;
                  no_error <= 1'b0;
                  timer    <= '0;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            ERR: begin
               // Clearing while ack is still high would re-enter IDLE mid-handshake
               if (err_clr && !ack) begin
                  state    <= IDLE;
                  no_error <= 1'b1;
                  timer    <= '0;
               end
            end
            default: begin
               state <= IDLE;
               timer <= '0;
            end
         endcase
      end
   end

`ifdef REQ_ACK_SRC_DEFERRED_ASSERT_EN
   // Deferred protocol checks evaluated once combinational logic has settled
   always_comb begin
      assert #0 (data_valid == req);
      assert final (!(state == IDLE && req));
      assume #0 (!(state == IDLE && ack));
      cover #0 (data_valid && data == {DATA_W{1'b1}});
   end
`endif

endmodule
